// File: rtl/row_buf_pkg.sv
// rtl/row_buf_pkg.sv - shared types, default parameters and width helpers for row_buf_bank
// Purpose: read-FSM state type, default parameter values and the index/bank
//          pointer width functions used by row_buf_bank and row_buf_mem.
// Ports:   none (package).
package row_buf_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

   localparam int DEF_DATA_W    = 64;
   localparam int DEF_ROW_WORDS = 4;
   localparam int DEF_NUM_BANKS = 2;
   localparam int DEF_REP_W     = 4;

   // Word index width inside one row; never narrower than one bit.
   function automatic int idx_w(input int row_words);
      return (row_words > 1) ? $clog2(row_words) : 1;
   endfunction

   // Bank pointer width; never narrower than one bit.
   function automatic int bank_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/row_buf_mem.sv
// rtl/row_buf_mem.sv - one row bank: register array with a write port and an asynchronous read
// Purpose: holds ROW_WORDS words of one bank. Synchronous reset clears every word.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          we, waddr, wdata  - write port
//          raddr, rdata      - asynchronous read port
module row_buf_mem
   import row_buf_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ROW_WORDS = DEF_ROW_WORDS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [idx_w(ROW_WORDS)-1:0]   waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [idx_w(ROW_WORDS)-1:0]   raddr,
   output logic [DATA_W-1:0]             rdata
);

   logic [DATA_W-1:0] words [ROW_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROW_WORDS; i++) begin
            words[i] <= '0;
         end
      end else if (we) begin
         words[waddr] <= wdata;
      end
   end

   assign rdata = words[raddr];

endmodule

// File: rtl/row_buf_bank.sv
// rtl/row_buf_bank.sv - multi-bank row buffer between the input FIFO and the PE array
// Purpose: rows are written into a free bank and committed; committed rows are
//          streamed word by word (optionally replayed) over a valid/ready handshake
//          while the next bank fills.
// Ports:   clk, rst                         - clock, synchronous active-high reset
//          wr_en, wr_addr, wr_data          - word write into the current write bank
//          wr_commit, wr_repeat, wr_ready   - commit current bank with replay count; bank free
//          out_data, out_valid, out_ready   - registered word stream to the PE array
//          out_first, out_last              - word 0 of a pass; last word of the final pass
//          ovf                              - sticky: write/commit attempted while not ready
module row_buf_bank
   import row_buf_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ROW_WORDS = DEF_ROW_WORDS,
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int REP_W     = DEF_REP_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [idx_w(ROW_WORDS)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          wr_commit,
   input  logic [REP_W-1:0]              wr_repeat,
   output logic                          wr_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_first,
   output logic                          out_last,
   output logic                          ovf
);

   localparam int IDX_W  = idx_w(ROW_WORDS);
   localparam int BANK_W = bank_w(NUM_BANKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WORDS - 1);

   rd_state_t         state, state_nxt;
   logic [BANK_W-1:0] wr_bank, rd_bank, rd_bank_inc, rd_bank_nxt, ld_bank;
   logic [NUM_BANKS-1:0] full;
   logic [REP_W-1:0]  rep [NUM_BANKS];
   logic [IDX_W-1:0]  idx, idx_inc, idx_nxt, ld_idx;
   logic [REP_W-1:0]  pass, pass_nxt;
   logic              valid_nxt, first_nxt, last_nxt;
   logic              load, release_row, xfer;
   logic              wr_ok, commit_ok;
   logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
   logic [DATA_W-1:0] ld_word;

   assign wr_ready    = !full[wr_bank];
   assign wr_ok       = wr_en && wr_ready;
   assign commit_ok   = wr_commit && wr_ready;
   assign xfer        = out_valid && out_ready;
   assign rd_bank_inc = rd_bank + 1'b1;
   assign idx_inc     = idx + 1'b1;

   // All banks share one read index; the bank being loaded is selected after.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      row_buf_mem #(
         .DATA_W    (DATA_W),
         .ROW_WORDS (ROW_WORDS)
      ) u_mem (
         .clk   (clk),
         .rst   (rst),
         .we    (wr_ok && (wr_bank == BANK_W'(b))),
         .waddr (wr_addr),
         .wdata (wr_data),
         .raddr (ld_idx),
         .rdata (bank_rdata[b])
      );
   end

   assign ld_word = bank_rdata[ld_bank];

   // Write pointer, full flags, replay counts and the sticky overflow flag.
   // A releasing bank is always full and a committing bank is always empty,
   // so release and commit on the same edge never touch the same flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= '0;
         full    <= '0;
         ovf     <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            rep[b] <= '0;
         end
      end else begin
         if ((wr_en || wr_commit) && !wr_ready) begin
            ovf <= 1'b1;
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (release_row && (rd_bank == BANK_W'(b))) begin
               full[b] <= 1'b0;
            end
            if (commit_ok && (wr_bank == BANK_W'(b))) begin
               full[b] <= 1'b1;
               rep[b]  <= wr_repeat;
            end
         end
         if (commit_ok) begin
            wr_bank <= wr_bank + 1'b1;
         end
      end
   end

   // Read FSM: next state, output register loads and pointer updates.
   always_comb begin
      state_nxt   = state;
      rd_bank_nxt = rd_bank;
      idx_nxt     = idx;
      pass_nxt    = pass;
      valid_nxt   = out_valid;
      first_nxt   = out_first;
      last_nxt    = out_last;
      load        = 1'b0;
      ld_bank     = rd_bank;
      ld_idx      = '0;
      release_row = 1'b0;

      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               load      = 1'b1;
               idx_nxt   = '0;
               pass_nxt  = rep[rd_bank];
               valid_nxt = 1'b1;
               first_nxt = 1'b1;
               last_nxt  = 1'b0;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (idx != LAST_IDX) begin
                  load      = 1'b1;
                  ld_idx    = idx_inc;
                  idx_nxt   = idx_inc;
                  first_nxt = 1'b0;
                  last_nxt  = (idx_inc == LAST_IDX) && (pass == '0);
               end else if (pass != '0) begin
                  // Replay: restart the same row from word 0.
                  load      = 1'b1;
                  idx_nxt   = '0;
                  pass_nxt  = pass - 1'b1;
                  first_nxt = 1'b1;
                  last_nxt  = 1'b0;
               end else begin
                  release_row = 1'b1;
                  rd_bank_nxt = rd_bank_inc;
                  if (full[rd_bank_inc]) begin
                     // Next row already committed: chain into it without a bubble.
                     load      = 1'b1;
                     ld_bank   = rd_bank_inc;
                     idx_nxt   = '0;
                     pass_nxt  = rep[rd_bank_inc];
                     first_nxt = 1'b1;
                     last_nxt  = 1'b0;
                  end else begin
                     valid_nxt = 1'b0;
                     first_nxt = 1'b0;
                     last_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_bank   <= '0;
         idx       <= '0;
         pass      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_bank   <= rd_bank_nxt;
         idx       <= idx_nxt;
         pass      <= pass_nxt;
         out_valid <= valid_nxt;
         out_first <= first_nxt;
         out_last  <= last_nxt;
         if (load) begin
            out_data <= ld_word;
         end
      end
   end

endmodule

// File: tb/tb_row_buf_bank.sv
// tb/tb_row_buf_bank.sv - self-checking bench for row_buf_bank
// Purpose: directed sequences, a table of replay/stall vectors and a randomized
//          run against a queue-based reference model.
// Ports:   none (testbench top).
module tb_row_buf_bank;

   localparam int DATA_W    = 64;
   localparam int ROW_WORDS = 4;
   localparam int NUM_BANKS = 2;
   localparam int REP_W     = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [1:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_commit;
   logic [REP_W-1:0]  wr_repeat;
   logic              wr_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_first;
   logic              out_last;
   logic              ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int rep;
      bit toggle;
      int xfers;
      int firsts;
      int lasts;
      int valid_cycles;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      bit          first;
      bit          last;
      int          bank;
      int          stamp;
   } exp_t;

   vec_t        vecs [5];
   logic [63:0] mmem [NUM_BANKS][ROW_WORDS];
   bit          mfull [NUM_BANKS];
   int          wptr;
   bit          movf;
   exp_t        exq [$];
   int          sample_n;

   row_buf_bank #(
      .DATA_W    (DATA_W),
      .ROW_WORDS (ROW_WORDS),
      .NUM_BANKS (NUM_BANKS),
      .REP_W     (REP_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_commit (wr_commit),
      .wr_repeat (wr_repeat),
      .wr_ready  (wr_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      wr_repeat = '0;
   endtask

   task automatic write_word(input int addr, input logic [63:0] data, input bit commit,
                             input int rpt);
      wr_en     = 1'b1;
      wr_addr   = addr[1:0];
      wr_data   = data;
      wr_commit = commit;
      wr_repeat = rpt[REP_W-1:0];
      tick();
      quiet();
   endtask

   // Reference model step, called once per cycle between edges: compare the
   // outputs seen now, then apply the effect of the upcoming edge.
   task automatic model_step();
      bit   acc;
      exp_t e;
      sample_n++;
      chk("rnd_wr_ready", wr_ready, !mfull[wptr]);
      chk("rnd_ovf", ovf, movf);
      if (exq.size() == 0) begin
         chk("rnd_idle_valid", out_valid, 0);
      end else if (out_valid) begin
         chk("rnd_data", out_data, exq[0].data);
         chk("rnd_first", out_first, exq[0].first);
         chk("rnd_last", out_last, exq[0].last);
      end else if (exq[0].stamp + 2 <= sample_n) begin
         chk("rnd_bubble", out_valid, 1);
      end
      acc = !mfull[wptr];
      if (out_valid && out_ready && exq.size() > 0) begin
         e = exq.pop_front();
         if (e.last) mfull[e.bank] = 1'b0;
      end
      if (wr_en) begin
         if (acc) mmem[wptr][wr_addr] = wr_data;
         else     movf = 1'b1;
      end
      if (wr_commit) begin
         if (acc) begin
            mfull[wptr] = 1'b1;
            for (int p = 0; p <= int'(wr_repeat); p++) begin
               for (int w = 0; w < ROW_WORDS; w++) begin
                  e.data  = mmem[wptr][w];
                  e.first = (w == 0);
                  e.last  = (w == ROW_WORDS - 1) && (p == int'(wr_repeat));
                  e.bank  = wptr;
                  e.stamp = sample_n;
                  exq.push_back(e);
               end
            end
            wptr = (wptr + 1) % NUM_BANKS;
         end else begin
            movf = 1'b1;
         end
      end
   endtask

   initial begin
      logic [63:0] base, held, expv;
      int xf, fi, la, vc, last_pos;
      bit prev_stall;

      vecs[0] = '{0, 1'b0, 4, 1, 1, 4};
      vecs[1] = '{2, 1'b0, 12, 3, 1, 12};
      vecs[2] = '{0, 1'b1, 4, 1, 1, 7};
      vecs[3] = '{1, 1'b1, 8, 2, 1, 15};
      vecs[4] = '{3, 1'b1, 16, 4, 1, 31};

      quiet();
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_first", out_first, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ovf", ovf, 0);

      // Basic row: 0x11..0x44, repeat 0, separate commit cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) write_word(i, 64'h11 * (i + 1), 1'b0, 0);
      wr_commit = 1'b1;
      tick();
      quiet();
      chk("basic_valid_after_commit", out_valid, 0);
      chk("basic_wr_ready_bank1", wr_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("basic_valid", out_valid, 1);
         chk("basic_data", out_data, 64'h11 * (i + 1));
         chk("basic_first", out_first, i == 0);
         chk("basic_last", out_last, i == 3);
      end
      tick();
      chk("basic_valid_end", out_valid, 0);

      // Table: replay counts with continuous or 1-0 toggling ready.
      for (int vi = 0; vi < 5; vi++) begin
         base = 64'h1000 * (vi + 1);
         for (int i = 0; i < 4; i++) write_word(i, base + i, i == 3, vecs[vi].rep);
         xf = 0; fi = 0; la = 0; vc = 0; last_pos = -1; prev_stall = 1'b0; held = '0;
         for (int c = 0; c < 200; c++) begin
            out_ready = vecs[vi].toggle ? (c % 2 == 1) : 1'b1;
            if (out_valid) begin
               vc++;
               if (prev_stall) chk("tbl_hold", out_data, held);
               if (out_ready) begin
                  expv = base + (xf % 4);
                  chk("tbl_data", out_data, expv);
                  chk("tbl_first", out_first, xf % 4 == 0);
                  if (out_first) fi++;
                  if (out_last) begin
                     la++;
                     last_pos = xf;
                  end
                  xf++;
                  prev_stall = 1'b0;
               end else begin
                  prev_stall = 1'b1;
                  held = out_data;
               end
            end else if (c > 1) begin
               break;
            end
            tick();
         end
         out_ready = 1'b1;
         chk("tbl_xfers", xf, vecs[vi].xfers);
         chk("tbl_firsts", fi, vecs[vi].firsts);
         chk("tbl_lasts", la, vecs[vi].lasts);
         chk("tbl_last_pos", last_pos, vecs[vi].xfers - 1);
         chk("tbl_valid_cycles", vc, vecs[vi].valid_cycles);
      end

      // Back-to-back rows, overflow while both banks are full.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(i, 64'hA0 + i, i == 3, 0);
      for (int i = 0; i < 4; i++) write_word(i, 64'hB0 + i, i == 3, 0);
      chk("full_wr_ready", wr_ready, 0);
      chk("full_ovf_clear", ovf, 0);
      chk("full_valid", out_valid, 1);
      write_word(0, 64'hEE, 1'b1, 5);
      chk("ovf_set", ovf, 1);
      chk("ovf_wr_ready", wr_ready, 0);
      chk("stall_hold", out_data, 64'hA0);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expv = (k < 4) ? (64'hA0 + k) : (64'hB0 + k - 4);
         chk("b2b_valid", out_valid, 1);
         chk("b2b_data", out_data, expv);
         chk("b2b_first", out_first, (k % 4) == 0);
         chk("b2b_last", out_last, (k % 4) == 3);
         if (k == 3) chk("b2b_wr_ready_before", wr_ready, 0);
         if (k == 4) chk("b2b_wr_ready_release", wr_ready, 1);
         tick();
      end
      chk("b2b_valid_end", out_valid, 0);
      chk("ovf_sticky", ovf, 1);

      // Reset mid-stream after two words.
      for (int i = 0; i < 4; i++) write_word(i, 64'h51 + i, i == 3, 0);
      tick();
      tick();
      tick();
      chk("mid_data_before_rst", out_data, 64'h53);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_wr_ready", wr_ready, 1);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_data", out_data, 0);
      for (int i = 0; i < 4; i++) write_word(i, 64'h61 + i, i == 3, 0);
      tick();
      chk("fresh_valid", out_valid, 1);
      chk("fresh_data", out_data, 64'h61);
      chk("fresh_first", out_first, 1);
      for (int i = 0; i < 5; i++) tick();

      // Randomized run against the reference model.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      quiet();
      out_ready = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         mfull[b] = 1'b0;
         for (int w = 0; w < ROW_WORDS; w++) mmem[b][w] = '0;
      end
      wptr = 0;
      movf = 1'b0;
      sample_n = 0;
      exq.delete();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_addr   = 2'($urandom_range(0, 3));
         wr_data   = {$urandom, $urandom};
         wr_commit = ($urandom_range(0, 5) == 0);
         wr_repeat = REP_W'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         model_step();
      end
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         quiet();
         out_ready = 1'b1;
         @(negedge clk);
         model_step();
      end
      chk("rnd_drained", exq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
